// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, common host commands and a parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a registered falling-edge strobe
// on the clock line. Shared by the host transmitter and the scan-code receiver.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin_i,
  input  logic dat_pin_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall_q;

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= clk_pin_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= dat_pin_i;
      dat_sync_q <= dat_meta_q;
      fall_q     <= clk_prev_q & ~clk_sync_q;
    end
  end

  assign clk_s_o = clk_sync_q;
  assign dat_s_o = dat_sync_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 bit frame, device ACK.
// Optional watchdog on device clock edges is enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);

  ps2_state_e       state_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [9:0]       frame_q;
  logic [3:0]       bit_idx_q;
  logic             tx_ready_q, done_q, error_q;
  logic [1:0]       err_code_q;
  logic             clk_oe_q, dat_oe_q;
  logic             clk_s, dat_s, fall;

  ps2_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_pin_i (ps2_clk_in),
    .dat_pin_i (ps2_dat_in),
    .clk_s_o   (clk_s),
    .dat_s_o   (dat_s),
    .fall_o    (fall)
  );

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_active;
  assign wd_active = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inh_cnt_q  <= INH_LOAD;
      frame_q    <= '0;
      bit_idx_q  <= '0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd_q       <= WD_LOAD;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if (fall) wd_q <= WD_LOAD;
      else if (wd_q != '0) wd_q <= wd_q - 1'b1;
      if (wd_active && wd_q == '0) begin
        error_q    <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        clk_oe_q   <= 1'b0;
        dat_oe_q   <= 1'b0;
        state_q    <= IDLE;
      end else
`endif
      case (state_q)
        IDLE: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (tx_valid && tx_ready_q) begin
            frame_q    <= {1'b1, odd_parity(tx_data), tx_data};
            bit_idx_q  <= '0;
            inh_cnt_q  <= INH_LOAD;
            clk_oe_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= INHIBIT;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        INHIBIT: begin
          if (inh_cnt_q == '0) begin
            dat_oe_q <= 1'b1;
            state_q  <= REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q - 1'b1;
          end
        end
        REQ: begin
          clk_oe_q <= 1'b0;
          state_q  <= SEND;
`ifdef PS2_HOST_TX_TIMEOUT_EN
          wd_q     <= WD_LOAD;
`endif
        end
        // Bit k of the frame goes out after fall k+1; index 9 is the stop bit (line released).
        SEND: begin
          if (fall) begin
            dat_oe_q <= ~frame_q[bit_idx_q];
            if (bit_idx_q == 4'd9) state_q <= ACK;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            if (!dat_s) begin
              state_q <= WAIT_IDLE;
            end else begin
              error_q    <= 1'b1;
              err_code_q <= ERR_NACK;
              state_q    <= IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready   = tx_ready_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames, expected bits and
// transfer outcomes are queued by the stimulus and consumed by an independent monitor.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 5000;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TO = 3000;
`else
  localparam int TO = 750000;
`endif

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } outcome_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1, dev_dat = 1'b1, dev_clk_prev = 1'b1;
  logic       mon_en = 1'b0, chk_ready_next = 1'b0;
  outcome_t   mon_e;
  logic       mon_b;
  int         total = 0, bad = 0;
  outcome_t   out_q[$];
  logic       bit_q[$];

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #10 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outcome pulses and the data line level seen at every device clock rise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_ready_next) begin
        check("ready_after_pulse", tx_ready, 1);
        check("pulse_one_cycle", {done, error}, 0);
        chk_ready_next = 1'b0;
      end else if (done || error) begin
        if (out_q.size() == 0) begin
          check("unexpected_pulse", {done, error}, 0);
        end else begin
          mon_e = out_q.pop_front();
          check("outcome", {done, error}, mon_e.is_err ? 2'b01 : 2'b10);
          if (mon_e.is_err) check("err_code", err_code, mon_e.code);
          chk_ready_next = 1'b1;
        end
      end
      if (dev_clk && !dev_clk_prev && bit_q.size() > 0) begin
        mon_b = bit_q.pop_front();
        check("dat_oe_bit", ps2_dat_oe, mon_b);
      end
    end
    dev_clk_prev = dev_clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dev_pulse();
    dev_clk = 1'b0;
    tick(20);
    dev_clk = 1'b1;
    tick(20);
  endtask

  // Issues the byte and checks inhibit length, request cycle and the first SEND cycle.
  task automatic accept_and_check(input logic [7:0] d);
    int n;
    check("ready_before", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("req_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
    @(negedge clk);
    check("start_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  // pat[k-1] is the dat_oe level expected after device fall k (k = 1..10).
  task automatic run_xfer(input logic [7:0] d, input logic [9:0] pat, input logic ack,
                          input int n_pulses, input logic poke);
    int n;
    for (int k = 0; k < 10 && k < n_pulses; k++) bit_q.push_back(pat[k]);
    if (n_pulses > 10) begin
      bit_q.push_back(1'b0);
      out_q.push_back(ack ? outcome_t'({1'b0, ERR_NONE}) : outcome_t'({1'b1, ERR_NACK}));
    end
    accept_and_check(d);
    tick(5);
    for (int k = 1; k <= n_pulses; k++) begin
      if (poke && k == 5) begin
        tx_data = 8'h55;
        tx_valid = 1'b1;
      end
      if (poke && k == 7) tx_valid = 1'b0;
      if (k == 11 && ack) begin
        dev_dat = 1'b0;
        tick(2);
      end
      dev_pulse();
      if (k == 11) dev_dat = 1'b1;
    end
    if (n_pulses > 10) begin
      n = 0;
      while (!tx_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("ready_wait_bound", n < 200, 1);
      tick(10);
      check("bus_released", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick(3);
    check("rst_outputs", {tx_ready, busy, done, error, err_code, ps2_clk_oe, ps2_dat_oe}, 8'b1000_0000);
    reset = 1'b0;
    tick(2);
    check("post_rst_idle", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    mon_en = 1'b1;

    run_xfer(CMD_SET_LEDS, 10'h012, 1'b1, 11, 1'b0);
    run_xfer(CMD_ENABLE,   10'h10B, 1'b0, 11, 1'b0);
    run_xfer(8'h00,        10'h0FF, 1'b1, 11, 1'b1);
    check("err_code_hold", err_code, ERR_NACK);

    run_xfer(CMD_RESET, 10'h000, 1'b1, 4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("midrst_ready", {tx_ready, busy, done, error}, 4'b1000);
    reset = 1'b0;
    tick(50);
    check("midrst_still_idle", {busy, ps2_clk_oe}, 0);

    run_xfer(CMD_RESET, 10'h000, 1'b1, 11, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    out_q.push_back(outcome_t'({1'b1, ERR_TIMEOUT}));
    accept_and_check(CMD_ENABLE);
    n = 0;
    while (!error && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TO);
    @(negedge clk);
    check("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick(5);
`endif

    check("outcomes_left", out_q.size(), 0);
    check("bits_left", bit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(200000 * 20);
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
